// File: rtl/ifu_fetch_pkg.sv
// Shared core definitions for the instruction fetch stage: address map defaults,
// fetch state type and the nop word substituted on fetch faults.
package ifu_fetch_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
    localparam logic [31:0] PC_LO_DEF    = 32'h0000_3000;
    localparam logic [31:0] PC_HI_DEF    = 32'h0000_6FFC;
    localparam logic [31:0] NOP_WORD     = 32'h0000_0000;

    typedef enum logic {
        FETCH = 1'b0,
        VALID = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/ifu_fetch_addr_check.sv
// Combinational word-alignment and legal-window check for a 32-bit address.
// Shared with the data-side load/store unit.
module ifu_addr_check #(
    parameter logic [31:0] LO = 32'h0000_3000,
    parameter logic [31:0] HI = 32'h0000_6FFC
) (
    input  logic [31:0] addr,
    output logic        adel
);

    assign adel = (addr[1:0] != 2'b00) || (addr < LO) || (addr > HI);

endmodule

// File: rtl/ifu_fetch.sv
// Fetch stage and architectural PC: one outstanding imem request at a time,
// instruction held for decode under a valid/stall handshake.
module ifu_fetch
    import ifu_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter logic [31:0] PC_LO    = PC_LO_DEF,
    parameter logic [31:0] PC_HI    = PC_HI_DEF,
    parameter int          MAX_WAIT = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] npc_in,
    output logic [31:0] pc_out,
    output logic [31:0] pc4_out,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_out,
    output logic        instr_valid,
    input  logic        stall,
    output logic        exc_adel,
    output logic        exc_tmo
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(MAX_WAIT - 1);

    fetch_state_t     state;
    logic [31:0]      pc;
    logic [31:0]      instr;
    logic             adel;
    logic             tmo;
    logic [CNT_W-1:0] wait_cnt;
    logic             run;
    logic             npc_adel;

    ifu_addr_check #(
        .LO (PC_LO),
        .HI (PC_HI)
    ) u_npc_check (
        .addr (npc_in),
        .adel (npc_adel)
    );

    // run holds the request off for the first cycle so imem_req rises only
    // after reset has been released and seen by a clock edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= FETCH;
            pc       <= RESET_PC;
            instr    <= NOP_WORD;
            adel     <= 1'b0;
            tmo      <= 1'b0;
            wait_cnt <= '0;
            run      <= 1'b0;
        end else begin
            run <= 1'b1;
            case (state)
                FETCH: begin
                    if (run) begin
                        if (imem_ack) begin
                            instr    <= imem_rdata;
                            state    <= VALID;
                            wait_cnt <= '0;
                        end else if (wait_cnt == LAST_WAIT) begin
                            instr    <= NOP_WORD;
                            tmo      <= 1'b1;
                            state    <= VALID;
                            wait_cnt <= '0;
                        end else begin
                            wait_cnt <= wait_cnt + 1'b1;
                        end
                    end
                end
                VALID: begin
                    // A bad next PC never reaches memory; the nop slot carries the error.
                    if (!stall) begin
                        pc  <= npc_in;
                        tmo <= 1'b0;
                        if (npc_adel) begin
                            instr <= NOP_WORD;
                            adel  <= 1'b1;
                        end else begin
                            adel  <= 1'b0;
                            state <= FETCH;
                        end
                    end
                end
            endcase
        end
    end

    assign pc_out      = pc;
    assign pc4_out     = pc + 32'd4;
    assign imem_req    = run && (state == FETCH);
    assign imem_addr   = pc;
    assign instr_out   = instr;
    assign instr_valid = (state == VALID);
    assign exc_adel    = adel;
    assign exc_tmo     = tmo;

endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: directed scenarios plus randomized
// fetch/consume traffic against a transaction-level reference model.
module tb_ifu_fetch;

    localparam int          MAX_WAIT = 16;
    localparam logic [31:0] LO       = 32'h0000_3000;
    localparam logic [31:0] HI       = 32'h0000_6FFC;
    localparam logic [31:0] RST_PC   = 32'h0000_3000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] npc_in = '0;
    logic [31:0] pc_out;
    logic [31:0] pc4_out;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] instr_out;
    logic        instr_valid;
    logic        stall = 1'b1;
    logic        exc_adel;
    logic        exc_tmo;

    int checks = 0;
    int errors = 0;

    // Reference model: what decode should currently be seeing.
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
    logic        exp_adel;
    logic        exp_tmo;

    ifu_fetch #(
        .RESET_PC (RST_PC),
        .PC_LO    (LO),
        .PC_HI    (HI),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .npc_in      (npc_in),
        .pc_out      (pc_out),
        .pc4_out     (pc4_out),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr_out   (instr_out),
        .instr_valid (instr_valid),
        .stall       (stall),
        .exc_adel    (exc_adel),
        .exc_tmo     (exc_tmo)
    );

    always #5 clk = ~clk;

    function automatic bit legal_pc(input logic [31:0] a);
        return (a[1:0] == 2'b00) && (a >= LO) && (a <= HI);
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (pc_out !== RST_PC || pc4_out !== RST_PC + 32'd4 || imem_req !== 1'b0 ||
            instr_valid !== 1'b0 || instr_out !== 32'h0 || exc_adel !== 1'b0 || exc_tmo !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_state: pc=%h pc4=%h req=%b valid=%b instr=%h adel=%b tmo=%b, required pc=%h pc4=%h req=0 valid=0 instr=0 adel=0 tmo=0",
                     pc_out, pc4_out, imem_req, instr_valid, instr_out, exc_adel, exc_tmo, RST_PC, RST_PC + 32'd4);
        end
        reset_n = 1'b1;
        next_cycle();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== RST_PC || instr_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_release: req=%b addr=%h valid=%b, required req=1 addr=%h valid=0",
                     imem_req, imem_addr, instr_valid, RST_PC);
        end
        exp_pc = RST_PC;
    endtask

    // Drives one memory transaction with ack after lat cycles; lat > MAX_WAIT
    // means the ack arrives late and must be ignored after the timeout.
    task automatic run_fetch(input int lat, input logic [31:0] data, input bit rand_stall, input string tag);
        int          done_at;
        int          c;
        int          exp_at;
        bit          want_tmo;
        logic [31:0] want_instr;
        done_at    = 0;
        c          = 0;
        exp_at     = (lat <= MAX_WAIT) ? lat : MAX_WAIT;
        want_tmo   = (lat > MAX_WAIT);
        want_instr = want_tmo ? 32'h0 : data;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== exp_pc || instr_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s_req: req=%b addr=%h valid=%b, required req=1 addr=%h valid=0",
                     tag, imem_req, imem_addr, instr_valid, exp_pc);
        end
        while (c < MAX_WAIT + 8 && !(done_at != 0 && c >= lat)) begin
            c++;
            imem_ack   = (c == lat);
            imem_rdata = (c == lat) ? data : $urandom;
            stall      = (done_at != 0) ? 1'b1 : (rand_stall ? 1'($urandom_range(0, 1)) : 1'b0);
            next_cycle();
            if (done_at == 0 && instr_valid === 1'b1) done_at = c;
        end
        imem_ack = 1'b0;
        stall    = 1'b1;
        checks++;
        if (done_at != exp_at) begin
            errors++;
            $display("[TB] FAIL %s_latency: valid after %0d cycles, required %0d", tag, done_at, exp_at);
        end
        checks++;
        if (instr_valid !== 1'b1 || instr_out !== want_instr || exc_tmo !== want_tmo ||
            exc_adel !== 1'b0 || imem_req !== 1'b0 || pc_out !== exp_pc) begin
            errors++;
            $display("[TB] FAIL %s_result: valid=%b instr=%h tmo=%b adel=%b req=%b pc=%h, required valid=1 instr=%h tmo=%b adel=0 req=0 pc=%h",
                     tag, instr_valid, instr_out, exc_tmo, exc_adel, imem_req, pc_out, want_instr, want_tmo, exp_pc);
        end
        exp_instr = want_instr;
        exp_tmo   = want_tmo;
        exp_adel  = 1'b0;
    endtask

    task automatic test_consume(input logic [31:0] npc, input string tag);
        stall  = 1'b0;
        npc_in = npc;
        next_cycle();
        stall  = 1'b1;
        exp_pc = npc;
        checks++;
        if (legal_pc(npc)) begin
            if (pc_out !== npc || pc4_out !== npc + 32'd4 || imem_req !== 1'b1 || imem_addr !== npc ||
                instr_valid !== 1'b0 || exc_adel !== 1'b0 || exc_tmo !== 1'b0) begin
                errors++;
                $display("[TB] FAIL %s_consume: pc=%h pc4=%h req=%b addr=%h valid=%b adel=%b tmo=%b, required pc=%h pc4=%h req=1 addr=%h valid=0 adel=0 tmo=0",
                         tag, pc_out, pc4_out, imem_req, imem_addr, instr_valid, exc_adel, exc_tmo, npc, npc + 32'd4, npc);
            end
        end else begin
            if (pc_out !== npc || pc4_out !== npc + 32'd4 || imem_req !== 1'b0 || instr_valid !== 1'b1 ||
                exc_adel !== 1'b1 || exc_tmo !== 1'b0 || instr_out !== 32'h0) begin
                errors++;
                $display("[TB] FAIL %s_adel: pc=%h pc4=%h req=%b valid=%b adel=%b tmo=%b instr=%h, required pc=%h pc4=%h req=0 valid=1 adel=1 tmo=0 instr=0",
                         tag, pc_out, pc4_out, imem_req, instr_valid, exc_adel, exc_tmo, instr_out, npc, npc + 32'd4);
            end
            exp_instr = 32'h0;
            exp_adel  = 1'b1;
            exp_tmo   = 1'b0;
        end
    endtask

    task automatic test_stall(input int cycles, input string tag);
        for (int i = 0; i < cycles; i++) begin
            stall      = 1'b1;
            npc_in     = $urandom;
            imem_ack   = 1'($urandom_range(0, 1));
            imem_rdata = $urandom;
            next_cycle();
            checks++;
            if (pc_out !== exp_pc || instr_out !== exp_instr || instr_valid !== 1'b1 || imem_req !== 1'b0 ||
                exc_adel !== exp_adel || exc_tmo !== exp_tmo) begin
                errors++;
                $display("[TB] FAIL %s_hold[%0d]: pc=%h instr=%h valid=%b req=%b adel=%b tmo=%b, required pc=%h instr=%h valid=1 req=0 adel=%b tmo=%b",
                         tag, i, pc_out, instr_out, instr_valid, imem_req, exc_adel, exc_tmo, exp_pc, exp_instr, exp_adel, exp_tmo);
            end
        end
        imem_ack = 1'b0;
    endtask

    task automatic test_addr_error();
        test_consume(32'h0000_3006, "misaligned");
        test_stall(2, "adel");
        test_consume(32'h0000_2FFC, "below_lo");
        test_consume(32'hFFFF_FFFC, "wrap");
        test_consume(HI, "at_hi");
        run_fetch(MAX_WAIT, 32'h2402_0005, 1'b0, "last_wait_ack");
        test_consume(HI + 32'd4, "above_hi");
        test_consume(LO, "at_lo");
        run_fetch(1, 32'h0000_000C, 1'b1, "after_adel");
    endtask

    task automatic test_timeout();
        test_consume(32'h0000_3010, "pre_tmo");
        run_fetch(MAX_WAIT + 3, 32'hDEAD_BEEF, 1'b0, "timeout");
        test_stall(3, "tmo");
        test_consume(32'h0000_3014, "post_tmo");
        run_fetch(2, 32'h8C22_0000, 1'b0, "post_tmo");
    endtask

    function automatic logic [31:0] pick_npc();
        logic [31:0] a;
        a = LO + 32'($urandom_range(0, int'((HI - LO) / 4))) * 32'd4;
        case ($urandom_range(0, 5))
            3:       a = a | 32'($urandom_range(1, 3));
            4:       a = 32'($urandom_range(0, int'(LO) - 1)) & 32'hFFFF_FFFC;
            5:       a = HI + 32'd4 + ($urandom & 32'h0FFF_FFFC);
            default: ;
        endcase
        return a;
    endfunction

    task automatic test_back_to_back(input int n);
        logic [31:0] npc;
        for (int i = 0; i < n; i++) begin
            npc = pick_npc();
            test_consume(npc, "rand");
            if (legal_pc(npc))
                run_fetch($urandom_range(1, MAX_WAIT + 2), $urandom, 1'b1, "rand");
            test_stall($urandom_range(0, 3), "rand");
        end
    endtask

    task automatic test_async_reset();
        test_consume(32'h0000_3020, "pre_reset");
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        checks++;
        if (pc_out !== RST_PC || imem_req !== 1'b0 || instr_valid !== 1'b0 || instr_out !== 32'h0 ||
            exc_adel !== 1'b0 || exc_tmo !== 1'b0) begin
            errors++;
            $display("[TB] FAIL async_reset: pc=%h req=%b valid=%b instr=%h adel=%b tmo=%b, required pc=%h req=0 valid=0 instr=0 adel=0 tmo=0",
                     pc_out, imem_req, instr_valid, instr_out, exc_adel, exc_tmo, RST_PC);
        end
        @(negedge clk);
        reset_n = 1'b1;
        next_cycle();
        exp_pc = RST_PC;
        run_fetch(2, 32'h3C01_0001, 1'b0, "after_reset");
    endtask

    initial begin
        test_reset();
        run_fetch(2, 32'h3C01_0001, 1'b0, "first_fetch");
        test_consume(32'h0000_3004, "next_pc");
        run_fetch(1, 32'h3421_0002, 1'b0, "min_latency");
        test_stall(5, "stall");
        test_consume(32'h0000_3008, "after_stall");
        run_fetch(3, 32'h0022_1820, 1'b1, "stall_ack");
        test_addr_error();
        test_timeout();
        test_back_to_back(40);
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
